barcode_scan_ctrl: RTL
======================

Name: barcode_scan_ctrl

Overview:
Sequencer for the 2-of-5 bar code reader datapath. Arms on request, validates the start symbol, and accepts 5-bit bar symbols over a valid/ready handshake. Decodes each symbol to a BCD digit, keeps a running mod-10 weighted checksum, and reports frame end (fim) or a coded error. Exposes its state for the board display, alongside the reader's existing state output.

Parameters:
NUM_DIGITS, 10, data symbols per frame including the final check digit (>=2)
START_SYM, 5'b11011, required first symbol of a frame (deliberately not a valid 2-of-5 code)
TIMEOUT_CYC, 255, maximum idle cycles between accepted symbols while a frame is in progress (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
arm  input  1  start a frame; sampled only in IDLE, DONE or ERROR
sym  input  5  bar symbol; weights sym[0]=1, sym[1]=2, sym[2]=4, sym[3]=7, sym[4]=parity(0)
sym_valid  input  1  sym is valid
sym_ready  output  1  controller accepts sym this cycle
digit  output  4  decoded BCD digit
digit_valid  output  1  one-cycle pulse, digit is valid
digit_idx  output  4  1-based position of digit in the frame
busy  output  1  frame in progress (WAIT_START, DIGIT or CHECK)
fim  output  1  frame completed OK; held high in DONE
err  output  1  held high in ERROR
err_code  output  3  0 none, 1 bad start, 2 bad symbol, 3 checksum, 4 timeout
state  output  4  current FSM state encoding

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0, including digit, digit_idx, err_code, checksum and timer.
- States and encodings: IDLE=0, WAIT_START=1, DIGIT=2, CHECK=3, DONE=4, ERROR=5.
- A transfer occurs when sym_valid && sym_ready on a rising edge.
- sym_ready=1 only in WAIT_START and DIGIT, combinational from state.
- IDLE/DONE/ERROR, arm=1 -> WAIT_START. On entry: clear fim, err, err_code, checksum, digit_idx and timer.
- arm is ignored while busy.
- WAIT_START, transfer:
  - sym==START_SYM -> DIGIT.
  - Otherwise -> ERROR with code 1.
- DIGIT, transfer:
  - Symbol must have exactly two ones; otherwise -> ERROR with code 2.
  - Decode: digit = sum of weights; sum 11 maps to 0.
  - digit_idx increments, then digit/digit_valid are registered, so digit_valid rises the cycle after the accepting edge.
  - Checksum update: odd positions add 3*d, even positions add d; result reduced mod 10 and held in 4 bits (max intermediate 9+27=36).
  - After transfer number NUM_DIGITS -> CHECK.
- CHECK (one cycle): checksum==0 -> DONE, else -> ERROR with code 3.
- DONE: fim=1 until the next arm. ERROR: err=1 and err_code held until the next arm.
- Timer:
  - Counts cycles in WAIT_START/DIGIT with no transfer; reset on each transfer.
  - Reaching TIMEOUT_CYC -> ERROR with code 4.
  - A transfer on the same cycle as expiry wins; no timeout is taken.
- An invalid symbol still produces no digit_valid pulse.
- Asynchronous reset mid-frame aborts immediately to IDLE; no fim or err is produced.

Optional Feature:
SCAN_CHECKSUM_EN
- Defined: CHECK evaluates the mod-10 checksum as above; a nonzero result gives err_code 3.
- Undefined: checksum logic is removed and CHECK always proceeds to DONE. err_code 3 is never produced.

Test Plan:
1. reset=0 mid-frame (state=2) -> next cycle state=0, fim=err=busy=sym_ready=0, err_code=0.
2. NUM_DIGITS=4, arm, then symbols 11011, 10001, 10010, 00011, 00110 (start, 1, 2, 3, 6) -> digit pulses 1, 2, 3, 6 with idx 1 to 4. Checksum 3+2+9+6=20 gives 0 -> state 3 then 4, fim=1.
3. Same frame with last symbol 01100 (digit 0) -> ERROR, err_code=3 with SCAN_CHECKSUM_EN defined. Without the macro -> fim=1.
4. arm, then symbol 10001 as the first symbol -> ERROR, err_code=1, no digit_valid pulse.
5. arm, start, then 00111 (three ones) -> ERROR, err_code=2, digit_valid stays 0.
6. TIMEOUT_CYC=8, arm, start, then sym_valid=0 for 8 cycles -> ERROR, err_code=4. Repeat with sym_valid=1 on the 8th cycle -> symbol accepted, no error. arm while busy -> no effect.

Source files
------------

// File: rtl/barcode_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : barcode_scan_ctrl
// Brief    : 2-of-5 bar code frame sequencer: start check, BCD decode,
//            mod-10 weighted checksum, timeout. Optional: SCAN_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module barcode_scan_ctrl #(
    parameter int         NUM_DIGITS  = 10,
    parameter logic [4:0] START_SYM   = 5'b11011,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arm,
    input  logic [4:0] sym,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic [3:0] digit_idx,
    output logic       busy,
    output logic       fim,
    output logic       err,
    output logic [2:0] err_code,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WAIT_START = 4'd1,
        S_DIGIT      = 4'd2,
        S_CHECK      = 4'd3,
        S_DONE       = 4'd4,
        S_ERROR      = 4'd5
    } state_t;

    localparam int              c_TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]      c_LAST_IDX = 4'(NUM_DIGITS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      w_err_code_nxt;
    logic [c_TW-1:0] r_timer;
    logic            w_xfer;
    logic            w_tmo;
    logic            w_go;
    logic            w_two_hot;
    logic [3:0]      w_wsum;
    logic [3:0]      w_dec;
    logic [3:0]      w_new_idx;
    logic            w_chk_ok;

    assign sym_ready = (r_state == S_WAIT_START) || (r_state == S_DIGIT);
    assign busy      = sym_ready || (r_state == S_CHECK);
    assign state     = r_state;
    assign w_xfer    = sym_valid && sym_ready;
    assign w_tmo     = !w_xfer && (r_timer == c_TMO_LAST);
    assign w_go      = arm && !busy;

    // Weights 1,2,4,7,0; the pair {4,7} sums to 11 and encodes digit 0.
    assign w_two_hot = ($countones(sym) == 2);
    assign w_wsum    = {3'b000, sym[0]} + {2'b00, sym[1], 1'b0} +
                       {1'b0, sym[2], 2'b00} + (sym[3] ? 4'd7 : 4'd0);
    assign w_dec     = (w_wsum == 4'd11) ? 4'd0 : w_wsum;
    assign w_new_idx = digit_idx + 4'd1;

`ifdef SCAN_CHECKSUM_EN
    logic [3:0] r_chk;
    logic [5:0] w_add;
    logic [5:0] w_sum;
    logic [3:0] w_mod;

    // Odd positions weigh 3, even positions weigh 1.
    assign w_add = w_new_idx[0] ? ({2'b00, w_dec} + {1'b0, w_dec, 1'b0})
                                : {2'b00, w_dec};
    assign w_sum = {2'b00, r_chk} + w_add;

    always_comb begin
        w_mod = 4'(w_sum);
        if (w_sum >= 6'd30)
            w_mod = 4'(w_sum - 6'd30);
        else if (w_sum >= 6'd20)
            w_mod = 4'(w_sum - 6'd20);
        else if (w_sum >= 6'd10)
            w_mod = 4'(w_sum - 6'd10);
    end

    assign w_chk_ok = (r_chk == 4'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_chk <= 4'd0;
        else if (w_go)
            r_chk <= 4'd0;
        else if (r_state == S_DIGIT && w_xfer && w_two_hot)
            r_chk <= w_mod;
    end
`else
    assign w_chk_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_err_code_nxt = 3'd0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (arm)
                    w_state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (w_xfer) begin
                    if (sym == START_SYM) begin
                        w_state_nxt = S_DIGIT;
                    end else begin
                        w_state_nxt    = S_ERROR;
                        w_err_code_nxt = 3'd1;
                    end
                end else if (w_tmo) begin
                    w_state_nxt    = S_ERROR;
                    w_err_code_nxt = 3'd4;
                end
            end
            S_DIGIT: begin
                if (w_xfer) begin
                    if (!w_two_hot) begin
                        w_state_nxt    = S_ERROR;
                        w_err_code_nxt = 3'd2;
                    end else if (digit_idx == c_LAST_IDX) begin
                        w_state_nxt = S_CHECK;
                    end
                end else if (w_tmo) begin
                    w_state_nxt    = S_ERROR;
                    w_err_code_nxt = 3'd4;
                end
            end
            S_CHECK: begin
                if (w_chk_ok) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt    = S_ERROR;
                    w_err_code_nxt = 3'd3;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer     <= '0;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            digit_idx   <= 4'd0;
            fim         <= 1'b0;
            err         <= 1'b0;
            err_code    <= 3'd0;
        end else begin
            digit_valid <= 1'b0;
            fim         <= (w_state_nxt == S_DONE);
            err         <= (w_state_nxt == S_ERROR);
            if (w_go) begin
                err_code  <= 3'd0;
                digit_idx <= 4'd0;
                r_timer   <= '0;
            end else if (w_state_nxt == S_ERROR && r_state != S_ERROR) begin
                err_code <= w_err_code_nxt;
            end
            if (sym_ready) begin
                if (w_xfer)
                    r_timer <= '0;
                else
                    r_timer <= r_timer + c_TW'(1);
            end
            if (r_state == S_DIGIT && w_xfer && w_two_hot) begin
                digit_idx   <= w_new_idx;
                digit       <= w_dec;
                digit_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
